// File: rtl/pmem_arbiter.sv
// Arbitrates NUM_CH cache-line requesters onto one burst-based physical memory port.
// Define PMEM_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module pmem_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int PMEM_WIDTH = 64,
    parameter int BEATS      = 4,
    localparam int LINE_BITS = PMEM_WIDTH * BEATS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_read,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*LINE_BITS-1:0]  req_wdata,
    output logic [NUM_CH-1:0]            req_resp,
    output logic [LINE_BITS-1:0]         req_rdata,
    output logic                         pmem_read,
    output logic                         pmem_write,
    input  logic                         pmem_resp,
    output logic [ADDR_WIDTH-1:0]        pmem_addr,
    output logic [PMEM_WIDTH-1:0]        pmem_wdata,
    input  logic [PMEM_WIDTH-1:0]        pmem_rdata
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

    // Requester handshake: a channel raises req_read/req_write with addr/wdata stable and
    // holds them until its one-cycle req_resp; the burst completes even if it lets go early.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CH_W-1:0]       chan_q;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       win_idx;
    logic                  win_valid;
    logic [CH_W:0]         cand_sum;
    logic [CH_W-1:0]       cand;
    logic [BEAT_W-1:0]     beat;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_BITS-1:0]  wline_q;
    logic [LINE_BITS-1:0]  rline_q;
    logic [NUM_CH-1:0]     eligible;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [LINE_BITS-1:0]  win_wdata;
    logic                  last_beat;

    assign eligible  = req_read | req_write;
    assign last_beat = pmem_resp && (beat == BEAT_W'(BEATS - 1));
    assign win_addr  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata = req_wdata[win_idx*LINE_BITS +: LINE_BITS];

    // Descending scan so the last hit is the first eligible channel at or after rr_ptr.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand_sum = {1'b0, rr_ptr} + (CH_W + 1)'(i);
            if (cand_sum >= (CH_W + 1)'(NUM_CH)) begin
                cand_sum = cand_sum - (CH_W + 1)'(NUM_CH);
            end
            cand = cand_sum[CH_W-1:0];
            if (eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_next = req_write[win_idx] ? WRITE : READ;
                end
            end
            READ, WRITE: begin
                if (last_beat) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q  <= '0;
            beat    <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        chan_q  <= win_idx;
                        addr_q  <= win_addr & ~OFF_MASK;
                        wline_q <= win_wdata;
                        beat    <= '0;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        rline_q[beat*PMEM_WIDTH +: PMEM_WIDTH] <= pmem_rdata;
                        beat <= last_beat ? '0 : beat + 1'b1;
                    end
                end
                WRITE: begin
                    if (pmem_resp) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PMEM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == RESP) begin
            rr_ptr <= (chan_q == CH_W'(NUM_CH - 1)) ? '0 : chan_q + 1'b1;
        end
    end
`endif

    assign pmem_read  = (state == READ);
    assign pmem_write = (state == WRITE);
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wline_q[beat*PMEM_WIDTH +: PMEM_WIDTH];
    assign req_rdata  = rline_q;

    always_comb begin
        req_resp = '0;
        if (state == RESP) begin
            req_resp[chan_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a two-channel instance for most checks and a
// four-channel instance for the read+write-on-one-channel case.
module tb_pmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-channel instance
    logic [1:0]   rd2, wr2, resp2;
    logic [63:0]  addr2;
    logic [511:0] wdata2;
    logic [255:0] rdata2;
    logic         pr2, pw2, presp2;
    logic [31:0]  paddr2;
    logic [63:0]  pwdata2, prdata2;

    // Four-channel instance
    logic [3:0]    rd4, wr4, resp4;
    logic [127:0]  addr4;
    logic [1023:0] wdata4;
    logic [255:0]  rdata4;
    logic          pr4, pw4, presp4;
    logic [31:0]   paddr4;
    logic [63:0]   pwdata4, prdata4;

    pmem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(32), .PMEM_WIDTH(64), .BEATS(4)) dut2 (
        .clk(clk), .rst(rst),
        .req_read(rd2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
        .req_resp(resp2), .req_rdata(rdata2),
        .pmem_read(pr2), .pmem_write(pw2), .pmem_resp(presp2),
        .pmem_addr(paddr2), .pmem_wdata(pwdata2), .pmem_rdata(prdata2)
    );

    pmem_arbiter #(.NUM_CH(4), .ADDR_WIDTH(32), .PMEM_WIDTH(64), .BEATS(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_read(rd4), .req_write(wr4), .req_addr(addr4), .req_wdata(wdata4),
        .req_resp(resp4), .req_rdata(rdata4),
        .pmem_read(pr4), .pmem_write(pw4), .pmem_resp(presp4),
        .pmem_addr(paddr4), .pmem_wdata(pwdata4), .pmem_rdata(prdata4)
    );

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        logic [1:0]  exp_resp;
        int          gap;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_val(input int i, input int k);
        logic [7:0] b;
        logic [7:0] tag;
        b   = 8'h11 * 8'(k + 1);
        tag = 8'(i);
        return {8{b}} ^ {tag, 56'h0};
    endfunction

    function automatic logic [255:0] wline_val(input int i);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            l[k*64 +: 64] = {32'hC0DE_0000 | 32'(i), 32'h0000_F000 | 32'(k)};
        end
        return l;
    endfunction

    task automatic clear_inputs();
        rd2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0; presp2 = 1'b0; prdata2 = '0;
        rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; presp4 = 1'b0; prdata4 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a burst to start on the two-channel instance; returns cycles waited.
    task automatic wait_busy2(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(pr2 | pw2) && cyc < 20);
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        logic [255:0] wl;
        logic [255:0] exp_line;
        int           cyc;
        wl       = wline_val(idx);
        exp_line = '0;
        if (v.wr) wr2[v.ch] = 1'b1;
        else      rd2[v.ch] = 1'b1;
        addr2[v.ch*32 +: 32]   = v.addr;
        wdata2[v.ch*256 +: 256] = wl;
        wait_busy2(cyc);
        check($sformatf("v%0d_grant_latency", idx), 256'(cyc), 256'd1);
        check($sformatf("v%0d_pmem_read", idx), 256'(pr2), 256'(!v.wr));
        check($sformatf("v%0d_pmem_write", idx), 256'(pw2), 256'(v.wr));
        if (!(pr2 | pw2)) begin
            rd2 = '0; wr2 = '0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                check($sformatf("v%0d_held_b%0d", idx, k), 256'(pr2 | pw2), 256'd1);
                check($sformatf("v%0d_no_resp_b%0d", idx, k), 256'(resp2), 256'd0);
                @(negedge clk);
            end
            presp2  = 1'b1;
            prdata2 = beat_val(idx, k);
            exp_line[k*64 +: 64] = beat_val(idx, k);
            check($sformatf("v%0d_addr_b%0d", idx, k), 256'(paddr2), 256'(v.exp_addr));
            if (v.wr) check($sformatf("v%0d_wdata_b%0d", idx, k), 256'(pwdata2), 256'(wl[k*64 +: 64]));
            @(negedge clk);
            presp2  = 1'b0;
            prdata2 = '0;
        end
        check($sformatf("v%0d_resp", idx), 256'(resp2), 256'(v.exp_resp));
        check($sformatf("v%0d_busy_after", idx), 256'(pr2 | pw2), 256'd0);
        if (!v.wr) check($sformatf("v%0d_rdata", idx), rdata2, exp_line);
        rd2 = '0; wr2 = '0;
        @(negedge clk);
        check($sformatf("v%0d_resp_once", idx), 256'(resp2), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          cyc;
        logic [1:0]  exp_seq[4];
        vec_t        v;
        logic [255:0] wl;

        vecs[0] = '{1, 1'b0, 32'h0000_1234, 32'h0000_1220, 2'b10, 0};
        vecs[1] = '{0, 1'b1, 32'h0000_0080, 32'h0000_0080, 2'b01, 0};
        vecs[2] = '{0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 2'b01, 1};
        vecs[3] = '{1, 1'b1, 32'h0000_001F, 32'h0000_0000, 2'b10, 0};
        vecs[4] = '{1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEE0, 2'b10, 5};
        vecs[5] = '{0, 1'b0, 32'h0000_0020, 32'h0000_0020, 2'b01, 2};
        vecs[6] = '{1, 1'b0, 32'h0000_0444, 32'h0000_0440, 2'b10, 0};

`ifdef PMEM_ARB_FIXED_PRIO_EN
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset_pmem_read", 256'(pr2), 256'd0);
        check("reset_pmem_write", 256'(pw2), 256'd0);
        check("reset_req_resp", 256'(resp2), 256'd0);
        check("reset_pmem_addr", 256'(paddr2), 256'd0);
        check("reset_pmem_wdata", 256'(pwdata2), 256'd0);
        check("reset_req_rdata", rdata2, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray pmem_resp while idle must not start anything or move the beat counter.
        for (int i = 0; i < 3; i++) begin
            presp2 = 1'b1;
            @(negedge clk);
            check("stray_resp_read", 256'(pr2), 256'd0);
            check("stray_resp_resp", 256'(resp2), 256'd0);
        end
        presp2 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(i, vecs[i]);
        end
        check("spec_read_line", 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111 ^
              {8'd5, 56'h0, 8'd5, 56'h0, 8'd5, 56'h0, 8'd5, 56'h0}, rdata2);

        // Reset partway through a read burst.
        rd2[1] = 1'b1;
        addr2[32 +: 32] = 32'h0000_0040;
        wait_busy2(cyc);
        check("rst_burst_start", 256'(pr2), 256'd1);
        for (int k = 0; k < 3; k++) begin
            presp2  = 1'b1;
            prdata2 = beat_val(9, k);
            @(negedge clk);
        end
        presp2 = 1'b0;
        rst    = 1'b1;
        rd2    = '0;
        @(negedge clk);
        check("rst_mid_pmem_read", 256'(pr2), 256'd0);
        check("rst_mid_req_resp", 256'(resp2), 256'd0);
        check("rst_mid_rdata", rdata2, 256'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_req_resp", 256'(resp2), 256'd0);
        check("rst_after_pmem_read", 256'(pr2), 256'd0);
        run_txn(6, vecs[6]);

        // Contention from reset: both channels read continuously.
        do_reset();
        rd2 = 2'b11;
        addr2 = {32'h0000_0200, 32'h0000_0100};
        for (int gi = 0; gi < 4; gi++) begin
            wait_busy2(cyc);
            check($sformatf("rr%0d_started", gi), 256'(pr2), 256'd1);
            check($sformatf("rr%0d_addr", gi), 256'(paddr2),
                  (exp_seq[gi] == 2'b01) ? 256'h100 : 256'h200);
            for (int k = 0; k < 4; k++) begin
                presp2  = 1'b1;
                prdata2 = beat_val(20 + gi, k);
                @(negedge clk);
            end
            presp2 = 1'b0;
            check($sformatf("rr%0d_grant", gi), 256'(resp2), 256'(exp_seq[gi]));
            if (gi == 3) rd2 = '0;
        end
        @(negedge clk);
        check("rr_quiet", 256'(pr2 | resp2), 256'd0);

        // Four channels: ch3 asserts read and write together; write wins.
        do_reset();
        wl = wline_val(30);
        rd4[3] = 1'b1;
        wr4[3] = 1'b1;
        addr4[96 +: 32] = 32'h0000_0100;
        wdata4[768 +: 256] = wl;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(pr4 | pw4) && cyc < 20);
        check("ch4_pmem_write", 256'(pw4), 256'd1);
        check("ch4_pmem_read", 256'(pr4), 256'd0);
        check("ch4_addr", 256'(paddr4), 256'h100);
        for (int k = 0; k < 4; k++) begin
            presp4 = 1'b1;
            check($sformatf("ch4_wdata_b%0d", k), 256'(pwdata4), 256'(wl[k*64 +: 64]));
            @(negedge clk);
        end
        presp4 = 1'b0;
        check("ch4_resp", 256'(resp4), 256'(4'b1000));
        rd4 = '0;
        wr4 = '0;
        @(negedge clk);
        check("ch4_resp_once", 256'(resp4), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
